enc_speed_meter: RTL and testbench

Converts the free-running 32-bit signed position produced by the quadrature encoder counter into speed measurements for the motor control loop. Each fixed sample window yields a position delta, a moving average of the last 2^AVG_LOG2 deltas, the interval in clock cycles between the two most recent count changes, and a stall flag. The block sits directly downstream of the encoder counter, with one instance per wheel, and feeds the register and readout stage.

---
 rtl/enc_speed_meter.sv | 149 ++++++++++++++
 tb/tb_enc_speed_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/enc_speed_meter.sv
// enc_speed_meter: turns a free-running signed encoder position into per-window
// speed (delta), a moving average of recent deltas, the interval between the two
// most recent position changes, and a stall indication.
module enc_speed_meter #(
  parameter int SAMPLE_CYCLES = 50000,  // window length in clk cycles, >= 2
  parameter int AVG_LOG2      = 2,      // moving-average depth is 2**AVG_LOG2, 0..4
  parameter int STALL_WINDOWS = 100     // zero-delta windows before stalled, >= 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] count,
  input  logic               enable,
  output logic signed [31:0] delta,
  output logic signed [31:0] delta_avg,
  output logic               valid,
  output logic        [31:0] period,
  output logic               stalled
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int TW    = $clog2(SAMPLE_CYCLES);
  localparam int SUMW  = 32 + AVG_LOG2;
  localparam int CW    = $clog2(STALL_WINDOWS + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] STALL_MAX  = CW'(STALL_WINDOWS);
  localparam logic [31:0]   SAT        = '1;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t state, state_next;
  logic                   terminal;
  logic [TW-1:0]          timer;
  logic signed [31:0]     prev_count;
  logic signed [31:0]     delta_next;
  logic signed [31:0]     hist [DEPTH];
  logic signed [SUMW-1:0] sum, sum_next;
  logic [CW-1:0]          stall_cnt, stall_cnt_next;

  logic signed [31:0]     count_d;
  logic                   loaded;
  logic                   armed;
  logic                   change;
  logic [31:0]            gap;

  // Window FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Window FSM next state; flags the terminal cycle of each window.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    terminal   = 1'b0;
    case (state)
      IDLE:    if (enable) state_next = PRIME;
      PRIME:   state_next = enable ? RUN : IDLE;
      RUN: begin
        if (!enable) state_next = IDLE;
        else         terminal   = (timer == TIMER_LAST);
      end
      default: state_next = IDLE;
    endcase
  end

  // Window timer: counts only while running, restarts on every other state.
  always_ff @(posedge clk) begin
    if (reset)                          timer <= '0;
    else if (state == RUN && enable)    timer <= terminal ? '0 : timer + TW'(1);
    else                                timer <= '0;
  end

  // Reference position for the current window, taken at PRIME and each terminal.
  always_ff @(posedge clk) begin
    if (reset)                                     prev_count <= '0;
    else if ((state == PRIME && enable) || terminal) prev_count <= count;
  end

  // Per-window arithmetic: modular delta, running sum update, stall run length.
  always_comb begin
    delta_next     = count - prev_count;
    sum_next       = sum + SUMW'(delta_next) - SUMW'(hist[DEPTH-1]);
    stall_cnt_next = '0;
    if (delta_next == 32'sd0)
      stall_cnt_next = (stall_cnt == STALL_MAX) ? STALL_MAX : stall_cnt + CW'(1);
  end

  // Window outputs and averaging history, updated only in the terminal cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      delta     <= '0;
      delta_avg <= '0;
      valid     <= 1'b0;
      stalled   <= 1'b1;
      sum       <= '0;
      stall_cnt <= '0;
      // NOTE: the history is reset explicitly; the running sum assumes it starts
      // at zero, and toggling enable must not be a way to clear it.
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      valid <= terminal;
      if (terminal) begin
        delta     <= delta_next;
        delta_avg <= 32'(sum_next >>> AVG_LOG2);
        sum       <= sum_next;
        stall_cnt <= stall_cnt_next;
        stalled   <= (stall_cnt_next >= STALL_MAX);
        for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= delta_next;
      end
    end
  end

  // A change is only meaningful once count_d holds a real sample.
  assign change = loaded && (count != count_d);

  // Period measurement between consecutive count changes, independent of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_d <= '0;
      loaded  <= 1'b0;
      armed   <= 1'b0;
      gap     <= '0;
      period  <= SAT;
    end else begin
      count_d <= count;
      loaded  <= 1'b1;
      if (change) begin
        gap   <= '0;
        armed <= 1'b1;
        if (armed) period <= (gap == SAT) ? SAT : gap + 32'd1;
      end else if (gap == SAT) begin
        period <= SAT;
      end else begin
        gap <= gap + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_enc_speed_meter.sv
// Directed bench for enc_speed_meter with a 10-cycle window, 4-deep average and
// a 3-window stall threshold.
module tb_enc_speed_meter;

  localparam int SC = 10;
  localparam int AL = 2;
  localparam int SW = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [31:0] count = '0;
  logic signed [31:0] delta;
  logic signed [31:0] delta_avg;
  logic               valid;
  logic        [31:0] period;
  logic               stalled;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int                 pul_cyc[$];
  logic signed [31:0] pul_delta[$];
  logic signed [31:0] pul_avg[$];
  logic               pul_stall[$];
  logic        [31:0] pul_period[$];

  enc_speed_meter #(
    .SAMPLE_CYCLES(SC),
    .AVG_LOG2     (AL),
    .STALL_WINDOWS(SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .enable   (enable),
    .delta    (delta),
    .delta_avg(delta_avg),
    .valid    (valid),
    .period   (period),
    .stalled  (stalled)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 ns after it and valid pulses logged.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) begin
      pul_cyc.push_back(cyc);
      pul_delta.push_back(delta);
      pul_avg.push_back(delta_avg);
      pul_stall.push_back(stalled);
      pul_period.push_back(period);
    end
  endtask

  // n edges; after every 'every'-th edge count moves by 'step' (every=0: hold).
  task automatic run(input int n, input int every, input int step);
    for (int i = 0; i < n; i++) begin
      tick();
      if (every != 0 && (i % every) == every - 1) count = count + step;
    end
  endtask

  task automatic clear_pulses();
    pul_cyc.delete();
    pul_delta.delete();
    pul_avg.delete();
    pul_stall.delete();
    pul_period.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_pulses();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (delta !== 32'sd0) begin failures++; $display("FAIL reset_delta got=%0d exp=0", delta); end
    checks++; if (delta_avg !== 32'sd0) begin failures++; $display("FAIL reset_avg got=%0d exp=0", delta_avg); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (period !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_period got=%h exp=ffffffff", period); end
    checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL reset_stalled got=%b exp=1", stalled); end
  endtask

  task automatic test_ramp();
    int base;
    int exp_avg[5] = '{1, 2, 3, 5, 5};
    count = 0;
    do_reset();
    enable = 1'b1;
    base = cyc;
    run(60, 2, 1);
    checks++; if (pul_cyc.size() != 5) begin failures++; $display("FAIL ramp_pulses got=%0d exp=5", pul_cyc.size()); end
    for (int k = 0; k < 5 && k < pul_cyc.size(); k++) begin
      checks++; if (pul_cyc[k] - base != 12 + SC * k) begin failures++; $display("FAIL ramp_time[%0d] got=%0d exp=%0d", k, pul_cyc[k] - base, 12 + SC * k); end
      checks++; if (pul_delta[k] !== 32'sd5) begin failures++; $display("FAIL ramp_delta[%0d] got=%0d exp=5", k, pul_delta[k]); end
      checks++; if (pul_avg[k] !== 32'(exp_avg[k])) begin failures++; $display("FAIL ramp_avg[%0d] got=%0d exp=%0d", k, pul_avg[k], exp_avg[k]); end
      checks++; if (pul_period[k] !== 32'd2) begin failures++; $display("FAIL ramp_period[%0d] got=%0d exp=2", k, pul_period[k]); end
    end
  endtask

  task automatic test_negative_and_wrap();
    count = 3;
    do_reset();
    enable = 1'b1;
    run(13, 2, -1);
    checks++; if (pul_cyc.size() != 1) begin failures++; $display("FAIL neg_pulses got=%0d exp=1", pul_cyc.size()); end
    if (pul_cyc.size() > 0) begin
      checks++; if (pul_delta[0] !== -32'sd5) begin failures++; $display("FAIL neg_delta got=%0d exp=-5", pul_delta[0]); end
      checks++; if (pul_avg[0] !== -32'sd2) begin failures++; $display("FAIL neg_avg got=%0d exp=-2", pul_avg[0]); end
    end

    count = 32'h7FFFFFFE;
    do_reset();
    enable = 1'b1;
    run(6, 0, 0);
    count = 32'h80000002;
    run(7, 0, 0);
    checks++; if (pul_cyc.size() != 1) begin failures++; $display("FAIL wrap_pulses got=%0d exp=1", pul_cyc.size()); end
    if (pul_cyc.size() > 0) begin
      checks++; if (pul_delta[0] !== 32'sd4) begin failures++; $display("FAIL wrap_delta got=%0d exp=4", pul_delta[0]); end
      checks++; if (pul_avg[0] !== 32'sd1) begin failures++; $display("FAIL wrap_avg got=%0d exp=1", pul_avg[0]); end
    end
  endtask

  task automatic test_stall();
    logic exp_st[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   exp_dl[4]  = '{5, 0, 0, 0};
    count = 100;
    do_reset();
    enable = 1'b1;
    run(2, 0, 0);
    count = 103;
    run(3, 0, 0);
    checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL stall_initial got=%b exp=1", stalled); end
    count = 105;
    run(40, 0, 0);
    checks++; if (pul_cyc.size() != 4) begin failures++; $display("FAIL stall_pulses got=%0d exp=4", pul_cyc.size()); end
    for (int k = 0; k < 4 && k < pul_cyc.size(); k++) begin
      checks++; if (pul_delta[k] !== 32'(exp_dl[k])) begin failures++; $display("FAIL stall_delta[%0d] got=%0d exp=%0d", k, pul_delta[k], exp_dl[k]); end
      checks++; if (pul_stall[k] !== exp_st[k]) begin failures++; $display("FAIL stall_flag[%0d] got=%b exp=%b", k, pul_stall[k], exp_st[k]); end
    end
    checks++; if (period !== 32'd3) begin failures++; $display("FAIL stall_period_hold got=%0d exp=3", period); end
  endtask

  task automatic test_enable_toggle();
    int base2;
    count = 0;
    do_reset();
    enable = 1'b1;
    run(12, 2, 1);
    run(4, 0, 0);
    enable = 1'b0;
    count  = count + 1000;
    run(20, 0, 0);
    checks++; if (pul_cyc.size() != 1) begin failures++; $display("FAIL en_disabled_pulses got=%0d exp=1", pul_cyc.size()); end
    checks++; if (delta !== 32'sd5) begin failures++; $display("FAIL en_delta_hold got=%0d exp=5", delta); end
    enable = 1'b1;
    base2  = cyc;
    run(3, 0, 0);
    count = count + 7;
    run(12, 0, 0);
    checks++; if (pul_cyc.size() != 2) begin failures++; $display("FAIL en_reenable_pulses got=%0d exp=2", pul_cyc.size()); end
    if (pul_cyc.size() > 1) begin
      checks++; if (pul_cyc[1] - base2 != 12) begin failures++; $display("FAIL en_first_time got=%0d exp=12", pul_cyc[1] - base2); end
      checks++; if (pul_delta[1] !== 32'sd7) begin failures++; $display("FAIL en_delta got=%0d exp=7", pul_delta[1]); end
      checks++; if (pul_avg[1] !== 32'sd3) begin failures++; $display("FAIL en_avg got=%0d exp=3", pul_avg[1]); end
    end
  endtask

  task automatic test_reset_mid_window();
    count = 0;
    do_reset();
    enable = 1'b1;
    run(12, 2, 1);
    run(6, 2, 1);
    reset = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid); end
    checks++; if (delta !== 32'sd0) begin failures++; $display("FAIL mid_delta got=%0d exp=0", delta); end
    checks++; if (delta_avg !== 32'sd0) begin failures++; $display("FAIL mid_avg got=%0d exp=0", delta_avg); end
    checks++; if (period !== 32'hFFFFFFFF) begin failures++; $display("FAIL mid_period got=%h exp=ffffffff", period); end
    checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL mid_stalled got=%b exp=1", stalled); end
    reset  = 1'b0;
    enable = 1'b0;
    run(12, 0, 0);
    checks++; if (pul_cyc.size() != 1) begin failures++; $display("FAIL mid_pulses got=%0d exp=1", pul_cyc.size()); end
    count = count + 1;
    run(7, 0, 0);
    checks++; if (period !== 32'hFFFFFFFF) begin failures++; $display("FAIL mid_first_change got=%h exp=ffffffff", period); end
    count = count + 1;
    run(1, 0, 0);
    checks++; if (period !== 32'd7) begin failures++; $display("FAIL mid_period7 got=%0d exp=7", period); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative_and_wrap();
    test_stall();
    test_enable_toggle();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
